ac97_tone_fifo_gen: RTL and testbench

Square-wave sample source that sits directly upstream of ac97_controller in the bit_clk domain. It produces signed 20-bit PCM samples at a programmable tone period and buffers them in a small first-word-fall-through FIFO. The controller reads the FIFO through its tone_data / fifo_empty / fifo_rd_en interface. The controller handles codec framing and volume registers; this block only generates and buffers samples.

---
 rtl/ac97_tone_fifo_gen.sv | 141 ++++++++++++++
 tb/tb_ac97_tone_fifo_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ac97_tone_fifo_gen.sv
// Square-wave PCM sample source feeding a small first-word-fall-through FIFO for ac97_controller.
// Optional macro TONE_ATTEN_EN adds a tone_atten[3:0] arithmetic right-shift applied at write time.
module ac97_tone_fifo_gen #(
   parameter int                 DEPTH     = 4,
   parameter logic signed [19:0] AMPLITUDE = 20'sd100000,
   parameter int                 PERIOD_W  = 16
) (
   input  logic                       bit_clk,
   input  logic                       reset_b,
   input  logic                       enable,
   input  logic [PERIOD_W-1:0]        tone_period,
`ifdef TONE_ATTEN_EN
   input  logic [3:0]                 tone_atten,
`endif
   output logic signed [19:0]         tone_data,
   output logic                       fifo_empty,
   input  logic                       fifo_rd_en,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [CW-1:0]         count_q, count_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  pol_q, pol_d;
   logic [PERIOD_W-1:0]   half_cnt_q, half_cnt_d;
   logic signed [19:0]    tone_data_q, tone_data_d;
   logic signed [19:0]    mem [DEPTH];

   logic                  wr_en;
   logic                  rd_en;
   logic                  period_zero;
   logic [PERIOD_W-1:0]   period_m1;
   logic signed [19:0]    raw_sample;
   logic signed [19:0]    sample;

`ifdef TONE_ATTEN_EN
   function automatic logic signed [19:0] atten_shift(input logic signed [19:0] v,
                                                      input logic [3:0] sh);
      atten_shift = v >>> sh;
   endfunction
`endif

   always_comb begin
      wr_en       = enable && (count_q < FULL_CNT);
      rd_en       = fifo_rd_en && (count_q != '0);
      period_zero = (tone_period == '0);
      period_m1   = tone_period - PERIOD_W'(1);

      if (period_zero) begin
         raw_sample = '0;
      end else if (pol_q) begin
         raw_sample = AMPLITUDE;
      end else begin
         raw_sample = -AMPLITUDE;
      end

`ifdef TONE_ATTEN_EN
      sample = atten_shift(raw_sample, tone_atten);
`else
      sample = raw_sample;
`endif
   end

   // Phase advances only on samples that are actually written, so a full FIFO pauses the tone.
   always_comb begin
      half_cnt_d = half_cnt_q;
      pol_d      = pol_q;
      if (wr_en) begin
         if (period_zero) begin
            half_cnt_d = '0;
            pol_d      = 1'b1;
         end else if (half_cnt_q >= period_m1) begin
            half_cnt_d = '0;
            pol_d      = ~pol_q;
         end else begin
            half_cnt_d = half_cnt_q + PERIOD_W'(1);
         end
      end
   end

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // The registered head must show a sample written this cycle when it lands at the new read slot.
      if (count_d == '0) begin
         tone_data_d = '0;
      end else if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
         tone_data_d = sample;
      end else begin
         tone_data_d = mem[rd_ptr_d];
      end
   end

   always_ff @(posedge bit_clk or negedge reset_b) begin
      if (!reset_b) begin
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         pol_q       <= 1'b1;
         half_cnt_q  <= '0;
         tone_data_q <= '0;
      end else begin
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         pol_q       <= pol_d;
         half_cnt_q  <= half_cnt_d;
         tone_data_q <= tone_data_d;
      end
   end

   always_ff @(posedge bit_clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= sample;
      end
   end

   assign tone_data  = tone_data_q;
   assign fifo_empty = (count_q == '0);
   assign fifo_count = count_q;

endmodule

// File: tb/tb_ac97_tone_fifo_gen.sv
// Directed bench for ac97_tone_fifo_gen: vector table for fill/streaming, hand sequences for stalls and reset.
module tb_ac97_tone_fifo_gen;

   localparam int A = 100000;
`ifdef TONE_ATTEN_EN
   localparam int AE = 25000;
`else
   localparam int AE = 100000;
`endif

   logic               bit_clk;
   logic               reset_b;
   logic               enable;
   logic [15:0]        tone_period;
   logic signed [19:0] tone_data;
   logic               fifo_empty;
   logic               fifo_rd_en;
   logic [2:0]         fifo_count;
`ifdef TONE_ATTEN_EN
   logic [3:0]         tone_atten;
`endif

   ac97_tone_fifo_gen dut (
      .bit_clk     (bit_clk),
      .reset_b     (reset_b),
      .enable      (enable),
      .tone_period (tone_period),
`ifdef TONE_ATTEN_EN
      .tone_atten  (tone_atten),
`endif
      .tone_data   (tone_data),
      .fifo_empty  (fifo_empty),
      .fifo_rd_en  (fifo_rd_en),
      .fifo_count  (fifo_count)
   );

   initial bit_clk = 1'b0;
   always #5 bit_clk = ~bit_clk;

   typedef struct {
      logic        en;
      logic        rd;
      logic [15:0] per;
      int          cnt;
      int          emp;
      int          dat;
   } vec_t;

   vec_t tbl [26];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic en, input logic rd, input logic [15:0] per,
                               input int cnt, input int emp, input int dat);
      vec_t v;
      v.en = en; v.rd = rd; v.per = per; v.cnt = cnt; v.emp = emp; v.dat = dat;
      return v;
   endfunction

   // Expected square wave for tone_period=2, counted from the first sample after reset.
   function automatic int sref(input int i);
      return (((i / 2) % 2) == 0) ? A : -A;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge bit_clk);
      #1;
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         enable      = tbl[i].en;
         fifo_rd_en  = tbl[i].rd;
         tone_period = tbl[i].per;
         tick();
         chk($sformatf("row%0d count", i), int'(fifo_count), tbl[i].cnt);
         chk($sformatf("row%0d empty", i), int'(fifo_empty), tbl[i].emp);
         chk($sformatf("row%0d data", i), int'(tone_data), tbl[i].dat);
      end
   endtask

   initial begin
      // fill after reset, period 2
      tbl[0]  = mk(1, 0, 2, 1, 0, A);
      tbl[1]  = mk(1, 0, 2, 2, 0, A);
      tbl[2]  = mk(1, 0, 2, 3, 0, A);
      tbl[3]  = mk(1, 0, 2, 4, 0, A);
      tbl[4]  = mk(1, 0, 2, 4, 0, A);
      // streaming at occupancy 1: head shows each freshly generated sample
      tbl[5]  = mk(1, 1, 0, 1, 0, 0);
      tbl[6]  = mk(1, 1, 0, 1, 0, 0);
      tbl[7]  = mk(1, 1, 3, 1, 0, A);
      tbl[8]  = mk(1, 1, 3, 1, 0, A);
      tbl[9]  = mk(1, 1, 3, 1, 0, A);
      tbl[10] = mk(1, 1, 3, 1, 0, -A);
      tbl[11] = mk(1, 1, 3, 1, 0, -A);
      tbl[12] = mk(1, 1, 3, 1, 0, -A);
      tbl[13] = mk(1, 1, 3, 1, 0, A);
      tbl[14] = mk(1, 1, 8, 1, 0, A);
      tbl[15] = mk(1, 1, 8, 1, 0, A);
      tbl[16] = mk(1, 1, 8, 1, 0, A);
      tbl[17] = mk(1, 1, 8, 1, 0, A);
      tbl[18] = mk(1, 1, 2, 1, 0, A);
      tbl[19] = mk(1, 1, 2, 1, 0, -A);
      tbl[20] = mk(1, 1, 2, 1, 0, -A);
      tbl[21] = mk(1, 1, 2, 1, 0, A);
      tbl[22] = mk(0, 1, 2, 0, 1, 0);
      tbl[23] = mk(0, 0, 2, 0, 1, 0);
      tbl[24] = mk(1, 0, 2, 1, 0, A);
      tbl[25] = mk(1, 0, 2, 2, 0, A);

      reset_b     = 1'b0;
      enable      = 1'b1;
      fifo_rd_en  = 1'b0;
      tone_period = 16'd2;
`ifdef TONE_ATTEN_EN
      tone_atten  = 4'd0;
`endif
      tick();
      tick();
      chk("reset count", int'(fifo_count), 0);
      chk("reset empty", int'(fifo_empty), 1);
      chk("reset data", int'(tone_data), 0);
      reset_b = 1'b1;

      run_rows(0, 4);

      // one pop every 4 cycles across full stalls
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("pop%0d data", k), int'(tone_data), sref(k));
         fifo_rd_en = 1'b1;
         tick();
         chk($sformatf("pop%0d count", k), int'(fifo_count), 3);
         fifo_rd_en = 1'b0;
         tick();
         chk($sformatf("refill%0d count", k), int'(fifo_count), 4);
         tick();
         tick();
      end

      // drain with generator off, then hammer reads on an empty FIFO
      enable     = 1'b0;
      fifo_rd_en = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tick();
         chk($sformatf("drain%0d count", j), int'(fifo_count), 3 - j);
         chk($sformatf("drain%0d data", j), int'(tone_data), (j < 3) ? sref(9 + j) : 0);
      end
      for (int j = 0; j < 10; j++) begin
         tick();
         chk($sformatf("underrun%0d count", j), int'(fifo_count), 0);
         chk($sformatf("underrun%0d empty", j), int'(fifo_empty), 1);
         chk($sformatf("underrun%0d data", j), int'(tone_data), 0);
      end
      enable     = 1'b1;
      fifo_rd_en = 1'b0;
      tick();
      chk("resume count", int'(fifo_count), 1);
      chk("resume data", int'(tone_data), sref(12));

      // full FIFO with a read every cycle
      tick();
      tick();
      tick();
      chk("full count", int'(fifo_count), 4);
      fifo_rd_en = 1'b1;
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("stream%0d data", k), int'(tone_data), sref(12 + k));
         tick();
         chk($sformatf("stream%0d count", k), int'(fifo_count), 3);
      end
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("tail%0d data", k), int'(tone_data), sref(24 + k));
         tick();
      end
      chk("tail count", int'(fifo_count), 0);

      run_rows(5, 25);

      // asynchronous reset in the middle of a fill
      enable      = 1'b1;
      fifo_rd_en  = 1'b0;
      tone_period = 16'd2;
`ifdef TONE_ATTEN_EN
      tone_atten  = 4'd2;
`endif
      tick();
      chk("prefill count", int'(fifo_count), 3);
      #3;
      reset_b = 1'b0;
      #1;
      chk("async rst count", int'(fifo_count), 0);
      chk("async rst empty", int'(fifo_empty), 1);
      chk("async rst data", int'(tone_data), 0);
      tick();
      chk("held rst count", int'(fifo_count), 0);
      reset_b = 1'b1;
      tick();
      chk("post rst count", int'(fifo_count), 1);
      chk("post rst s0", int'(tone_data), AE);
      fifo_rd_en = 1'b1;
      tick();
      chk("post rst s1", int'(tone_data), AE);
      tick();
      chk("post rst s2", int'(tone_data), -AE);
      tick();
      chk("post rst s3", int'(tone_data), -AE);
      tick();
      chk("post rst s4", int'(tone_data), AE);
      chk("post rst count2", int'(fifo_count), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
